// File: rtl/mips_multicycle_control_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control_if
// Bundles the signals between the multi-cycle control sequencer and the
// MIPS datapath.
//   Inputs to the controller : opcode (IR[31:26]) and mem_ready (memory done).
//   Outputs of the controller: PC/memory/IR/register-file enables, datapath
//                              mux selects, ALU operation, debug state,
//                              instr_done and illegal_op.
// The master modport is the controller; the slave modport is the datapath.
// ---------------------------------------------------------------------------
interface mips_multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       PCWriteCondNE;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       ExtOp;
   logic [2:0] ALUOp;
   logic [1:0] PCSource;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
             IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ExtOp,
             ALUOp, PCSource, state, instr_done, illegal_op
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
             IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ExtOp,
             ALUOp, PCSource, state, instr_done, illegal_op
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
// Multi-cycle control sequencer for a MIPS datapath sharing one memory port
// and one ALU. Supports R-type, LW, SW, BEQ, BNE, ADDI, ANDI, ORI and stalls
// on mem_ready during instruction fetch, load read and store write.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (state returns to FETCH)
//   bus   - master side of mips_multicycle_control_if (opcode/mem_ready in,
//           datapath controls, debug state, instr_done, illegal_op out)
// ---------------------------------------------------------------------------
module mips_multicycle_control (
   input  logic                        clk,
   input  logic                        rst_n,
   mips_multicycle_control_if.master   bus
);

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_LW   = 6'd35;
   localparam logic [5:0] OP_SW   = 6'd43;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_BNE  = 6'd5;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_ANDI = 6'd12;
   localparam logic [5:0] OP_ORI  = 6'd13;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10
   } state_t;

   state_t     state_q, state_d;

   logic       pc_write, pc_write_cond, pc_write_cond_ne;
   logic       iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, ext_op, instr_done, illegal_op;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d          = S_FETCH;
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      iord             = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_dst          = 1'b0;
      mem_to_reg       = 1'b0;
      reg_write        = 1'b0;
      alu_src_a        = 1'b0;
      alu_src_b        = 2'b00;
      ext_op           = 1'b1;
      alu_op           = 3'b000;
      pc_source        = 2'b00;
      instr_done       = 1'b0;
      illegal_op       = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC+4 is computed every fetch cycle but only committed with the IR.
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = bus.mem_ready;
            pc_write  = bus.mem_ready;
            state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // ALU is idle here, so precompute the branch target into ALUOut.
            alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW:              state_d = S_MEMADR;
               OP_R:                      state_d = S_EXEC;
               OP_BEQ, OP_BNE:            state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
               default: begin
                  state_d    = S_FETCH;
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = bus.mem_ready;
            state_d    = bus.mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            // ALU compares rs/rt; the target precomputed in DECODE sits in ALUOut.
            alu_src_a        = 1'b1;
            alu_op           = 3'b001;
            pc_source        = 2'b01;
            pc_write_cond    = (bus.opcode == OP_BEQ);
            pc_write_cond_ne = (bus.opcode == OP_BNE);
            instr_done       = 1'b1;
         end
         S_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (bus.opcode)
               OP_ANDI: begin alu_op = 3'b011; ext_op = 1'b0; end
               OP_ORI:  begin alu_op = 3'b100; ext_op = 1'b0; end
               default: begin alu_op = 3'b000; ext_op = 1'b1; end
            endcase
            state_d = S_IWB;
         end
         S_IWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            // Unused encodings: flag and fall back to FETCH.
            illegal_op = 1'b1;
         end
      endcase
   end

   // Enables are forced low while reset is asserted, even though the reset
   // state (FETCH) would otherwise drive MemRead/IRWrite/PCWrite.
   assign bus.PCWrite       = pc_write         & rst_n;
   assign bus.PCWriteCond   = pc_write_cond    & rst_n;
   assign bus.PCWriteCondNE = pc_write_cond_ne & rst_n;
   assign bus.IRWrite       = ir_write         & rst_n;
   assign bus.MemRead       = mem_read         & rst_n;
   assign bus.MemWrite      = mem_write        & rst_n;
   assign bus.RegWrite      = reg_write        & rst_n;
   assign bus.instr_done    = instr_done       & rst_n;
   assign bus.illegal_op    = illegal_op       & rst_n;
   assign bus.IorD          = iord;
   assign bus.RegDst        = reg_dst;
   assign bus.MemtoReg      = mem_to_reg;
   assign bus.ALUSrcA       = alu_src_a;
   assign bus.ALUSrcB       = alu_src_b;
   assign bus.ExtOp         = ext_op;
   assign bus.ALUOp         = alu_op;
   assign bus.PCSource      = pc_source;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
// Self-checking bench: each instruction is expanded into its expected step
// sequence and per-instruction enable totals from the instruction-class rules,
// then stimulated with random wait states and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                  ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_RWB = 7,
                  ST_BRANCH = 8, ST_IEXEC = 9, ST_IWB = 10;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BR = 3, K_I = 4, K_ILL = 5;

   typedef struct {
      int   st;
      logic mr;
   } step_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   mips_multicycle_control_if u_if ();

   mips_multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   logic [8:0] en_bus;
   assign en_bus = {u_if.PCWrite, u_if.PCWriteCond, u_if.PCWriteCondNE,
                    u_if.IRWrite, u_if.MemRead, u_if.MemWrite, u_if.RegWrite,
                    u_if.instr_done, u_if.illegal_op};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int kind_of(input logic [5:0] op);
      case (op)
         6'd35:               return K_LW;
         6'd43:               return K_SW;
         6'd0:                return K_R;
         6'd4, 6'd5:          return K_BR;
         6'd8, 6'd12, 6'd13:  return K_I;
         default:             return K_ILL;
      endcase
   endfunction

   // Runs one instruction with wf fetch wait cycles and wm data-memory wait
   // cycles. abort_at >= 0 drops rst_n right after that step's checks.
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int abort_at);
      step_t path[$];
      step_t s;
      int    k;
      int    c_mr, c_mw, c_iord, c_ir, c_pc, c_rw, c_pcc, c_pcne, c_ill, c_done;
      int    e_mr, e_mw, e_iord, e_rw;
      k = kind_of(op);
      c_mr = 0; c_mw = 0; c_iord = 0; c_ir = 0; c_pc = 0; c_rw = 0;
      c_pcc = 0; c_pcne = 0; c_ill = 0; c_done = 0;

      for (int i = 0; i < wf; i++) begin s.st = ST_FETCH; s.mr = 1'b0; path.push_back(s); end
      s.st = ST_FETCH;  s.mr = 1'b1;            path.push_back(s);
      s.st = ST_DECODE; s.mr = 1'($urandom);    path.push_back(s);
      case (k)
         K_LW: begin
            s.st = ST_MEMADR; s.mr = 1'($urandom); path.push_back(s);
            for (int i = 0; i < wm; i++) begin s.st = ST_MEMRD; s.mr = 1'b0; path.push_back(s); end
            s.st = ST_MEMRD; s.mr = 1'b1; path.push_back(s);
            s.st = ST_MEMWB; s.mr = 1'($urandom); path.push_back(s);
         end
         K_SW: begin
            s.st = ST_MEMADR; s.mr = 1'($urandom); path.push_back(s);
            for (int i = 0; i < wm; i++) begin s.st = ST_MEMWR; s.mr = 1'b0; path.push_back(s); end
            s.st = ST_MEMWR; s.mr = 1'b1; path.push_back(s);
         end
         K_R: begin
            s.st = ST_EXEC; s.mr = 1'($urandom); path.push_back(s);
            s.st = ST_RWB;  s.mr = 1'($urandom); path.push_back(s);
         end
         K_BR: begin
            s.st = ST_BRANCH; s.mr = 1'($urandom); path.push_back(s);
         end
         K_I: begin
            s.st = ST_IEXEC; s.mr = 1'($urandom); path.push_back(s);
            s.st = ST_IWB;   s.mr = 1'($urandom); path.push_back(s);
         end
         default: ;
      endcase

      for (int idx = 0; idx < path.size(); idx++) begin
         u_if.mem_ready = path[idx].mr;
         // The IR field is only meaningful from DECODE on; scramble it in FETCH.
         u_if.opcode = (path[idx].st == ST_FETCH) ? 6'($urandom) : op;
         @(negedge clk);
         check("state", 32'(u_if.state), 32'(path[idx].st));
         c_mr   += int'(u_if.MemRead);
         c_mw   += int'(u_if.MemWrite);
         c_iord += int'(u_if.IorD);
         c_ir   += int'(u_if.IRWrite);
         c_pc   += int'(u_if.PCWrite);
         c_rw   += int'(u_if.RegWrite);
         c_pcc  += int'(u_if.PCWriteCond);
         c_pcne += int'(u_if.PCWriteCondNE);
         c_ill  += int'(u_if.illegal_op);
         c_done += int'(u_if.instr_done);
         if (idx == wf) check("fetch_alusrcb", 32'(u_if.ALUSrcB), 32'd1);
         if (idx == wf + 1) check("decode_alusrcb", 32'(u_if.ALUSrcB), 32'd3);
         if (idx == wf + 2) begin
            if (k == K_R) check("exec_aluop", 32'(u_if.ALUOp), 32'd2);
            if (k == K_BR) begin
               check("br_aluop", 32'(u_if.ALUOp), 32'd1);
               check("br_pcsrc", 32'(u_if.PCSource), 32'd1);
            end
            if (k == K_I) begin
               check("iexec_aluop", 32'(u_if.ALUOp), (op == 6'd12) ? 32'd3 : (op == 6'd13) ? 32'd4 : 32'd0);
               check("iexec_extop", 32'(u_if.ExtOp), (op == 6'd8) ? 32'd1 : 32'd0);
               check("iexec_srcb", 32'(u_if.ALUSrcB), 32'd2);
            end
         end
         if (u_if.RegWrite) begin
            check("wb_regdst", 32'(u_if.RegDst), (k == K_R) ? 32'd1 : 32'd0);
            check("wb_memtoreg", 32'(u_if.MemtoReg), (k == K_LW) ? 32'd1 : 32'd0);
         end
         if (idx == path.size() - 1) check("done_last", 32'(u_if.instr_done), 32'd1);
         if (idx == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_state", 32'(u_if.state), 32'd0);
            check("abort_en", 32'(en_bus), 32'd0);
            @(posedge clk);
            #1;
            check("abort_hold_state", 32'(u_if.state), 32'd0);
            check("abort_hold_en", 32'(en_bus), 32'd0);
            rst_n = 1'b1;
            $display("op=%0d wf=%0d wm=%0d aborted at step %0d", op, wf, wm, idx);
            return;
         end
         @(posedge clk);
         #1;
      end

      e_mr   = wf + 1 + ((k == K_LW) ? wm + 1 : 0);
      e_mw   = (k == K_SW) ? wm + 1 : 0;
      e_iord = (k == K_LW || k == K_SW) ? wm + 1 : 0;
      e_rw   = (k == K_LW || k == K_R || k == K_I) ? 1 : 0;
      check("cnt_memread", 32'(c_mr), 32'(e_mr));
      check("cnt_memwrite", 32'(c_mw), 32'(e_mw));
      check("cnt_iord", 32'(c_iord), 32'(e_iord));
      check("cnt_irwrite", 32'(c_ir), 32'd1);
      check("cnt_pcwrite", 32'(c_pc), 32'd1);
      check("cnt_regwrite", 32'(c_rw), 32'(e_rw));
      check("cnt_pcwcond", 32'(c_pcc), (op == 6'd4) ? 32'd1 : 32'd0);
      check("cnt_pcwcondne", 32'(c_pcne), (op == 6'd5) ? 32'd1 : 32'd0);
      check("cnt_illegal", 32'(c_ill), (k == K_ILL) ? 32'd1 : 32'd0);
      check("cnt_done", 32'(c_done), 32'd1);
      $display("op=%0d wf=%0d wm=%0d cycles=%0d done=%0d", op, wf, wm, path.size(), c_done);
   endtask

   initial begin
      logic [5:0] legal_ops [8];
      logic [5:0] op;
      legal_ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13};

      // Reset held with mem_ready high: FETCH, all enables suppressed.
      rst_n = 1'b0;
      u_if.mem_ready = 1'b1;
      u_if.opcode = 6'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", 32'(u_if.state), 32'd0);
      check("rst_en", 32'(en_bus), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_instr(6'd35, 0, 0, -1);   // LW, no waits
      run_instr(6'd43, 0, 3, -1);   // SW, 3 wait cycles in MEMWR
      run_instr(6'd5,  0, 0, -1);   // BNE
      run_instr(6'd4,  0, 0, -1);   // BEQ
      run_instr(6'd12, 0, 0, -1);   // ANDI
      run_instr(6'd8,  0, 0, -1);   // ADDI
      run_instr(6'd2,  0, 0, -1);   // illegal
      run_instr(6'd35, 1, 3, 4);    // LW, reset during MEMRD stall
      run_instr(6'd0,  2, 0, -1);   // R-type after abort

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 99) < 85) begin
            op = legal_ops[$urandom_range(0, 7)];
         end else begin
            op = 6'($urandom);
            while (kind_of(op) != K_ILL) op = 6'($urandom);
         end
         run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
